// File: rtl/seq_muldiv_unit.sv
// Sequential radix-2 multiply/divide unit with architectural HI/LO, one result bit per cycle.
// Macro SEQ_MULDIV_SIGNED_EN builds signed MULT/DIV on op[0]; undefined, every op runs unsigned.
module seq_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             is_div, dz;
    logic [WIDTH-1:0] wk_hi, wk_lo, opnd;
    logic [WIDTH-1:0] mag_a, mag_b, st_hi, st_lo, res_hi, res_lo;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             accept, last;

    assign accept = start && (state != CALC);
    assign last   = (state == CALC) && (cnt == '0);

`ifdef SEQ_MULDIV_SIGNED_EN
    logic               sa, sb, neg_q, neg_r;
    logic [2*WIDTH-1:0] prod_neg;

    assign sa       = op[0] & a[WIDTH-1];
    assign sb       = op[0] & b[WIDTH-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;
    assign prod_neg = -{st_hi, st_lo};

    // Quotient/product sign is the xor of operand signs; remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end
    end
`else
    logic op_unused;
    assign op_unused = op[0];
    assign mag_a     = a;
    assign mag_b     = b;
`endif

    // wk_lo holds |a|: multiplier bits shift out the bottom, dividend bits shift out the top.
    always_comb begin
        mul_sum  = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {wk_hi, wk_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                st_hi = div_diff[WIDTH-1:0];
                st_lo = {wk_lo[WIDTH-2:0], 1'b1};
            end else begin
                st_hi = div_sh[WIDTH-1:0];
                st_lo = {wk_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            st_hi = mul_sum[WIDTH:1];
            st_lo = {mul_sum[0], wk_lo[WIDTH-1:1]};
        end
    end

    // Divide by zero leaves |a| in the remainder naturally; only the quotient needs forcing.
    always_comb begin
        res_hi = st_hi;
        res_lo = st_lo;
`ifdef SEQ_MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_q) res_lo = -st_lo;
            if (neg_r) res_hi = -st_hi;
        end else if (neg_q) begin
            {res_hi, res_lo} = prod_neg;
        end
`endif
        if (is_div && dz) res_lo = '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            wk_hi  <= '0;
            wk_lo  <= '0;
            opnd   <= '0;
        end else if (accept) begin
            cnt    <= CNT_TOP;
            is_div <= op[1];
            dz     <= (b == '0);
            wk_hi  <= '0;
            wk_lo  <= mag_a;
            opnd   <= mag_b;
        end else if (state == CALC) begin
            wk_hi <= st_hi;
            wk_lo <= st_lo;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (last) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state != CALC) begin
            if (we_hi) hi <= wd;
            if (we_lo) lo <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end
endmodule
